// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction memory write port out
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // master is the loader side, slave is the byte source / memory side
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles little-endian bytes into words and writes instruction memory
module imem_loader #(
  parameter int MEM_BYTES = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   num_words,
  input  logic         abort,
  imem_loader_if.master bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int MAX_WORDS = MEM_BYTES / 4;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  nw_q;
  logic [7:0]  word_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] word_buf;
  logic        err_q;
  logic        num_ok;
  logic        last_word;

  assign num_ok    = (num_words != 8'd0) && ({24'd0, num_words} <= 32'(MAX_WORDS));
  assign last_word = (word_idx == nw_q - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && num_ok) state_nxt = RECV;
      RECV: begin
        if (abort)                                      state_nxt = IDLE;
        else if (bus.byte_valid && byte_cnt == 2'd3)    state_nxt = WRITE;
      end
      WRITE: begin
        if (abort)          state_nxt = IDLE;
        else if (last_word) state_nxt = DONE;
        else                state_nxt = RECV;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // abort suppresses the write strobe combinationally in the same cycle
  always_comb begin
    bus.byte_ready = (state == RECV);
    bus.mem_we     = (state == WRITE) && !abort;
    busy           = (state == RECV) || (state == WRITE);
    cpu_hold       = (state != IDLE);
    done           = (state == DONE);
  end

  assign bus.mem_addr  = {22'd0, word_idx, 2'b00};
  assign bus.mem_wdata = word_buf;
  assign err           = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nw_q     <= 8'd0;
      word_idx <= 8'd0;
      byte_cnt <= 2'd0;
      word_buf <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (num_ok) begin
              err_q    <= 1'b0;
              nw_q     <= num_words;
              word_idx <= 8'd0;
              byte_cnt <= 2'd0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (abort) begin
            err_q <= 1'b1;
          end else if (bus.byte_valid) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          if (abort) begin
            err_q <= 1'b1;
          end else if (!last_word) begin
            word_idx <= word_idx + 8'd1;
            byte_cnt <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
